// File: rtl/iq_uart_pkg.sv
// Shared definitions for the I/Q UART transmitter and receiver pair:
// FSM state encoding, 8N1 frame constants and the I/Q sample pair type.
package iq_uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_GAP   = 3'd4
   } uart_state_e;

   // I is always sent first in a pair, Q second.
   typedef enum logic {
      PH_I = 1'b0,
      PH_Q = 1'b1
   } iq_phase_e;

   localparam int DATA_BITS  = 8;
   localparam int STOP_BITS  = 1;
   localparam int FRAME_BITS = 1 + DATA_BITS + STOP_BITS;
   localparam int BIT_IDX_W  = $clog2(DATA_BITS);

   typedef logic [DATA_BITS-1:0] sample_t;

   typedef struct packed {
      sample_t i;
      sample_t q;
   } iq_pair_t;

   // Counter width that stays at least one bit for tiny terminal counts.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/iq_uart_tx_if.sv
// Sample handshake between the I/Q sample source and the UART transmitter:
// a single-cycle valid strobe qualifying one I/Q pair.
interface iq_uart_tx_if;
   import iq_uart_pkg::*;

   logic    i_Sample_Valid;
   sample_t i_I_Data;
   sample_t i_Q_Data;

   modport master (
      output i_Sample_Valid,
      output i_I_Data,
      output i_Q_Data
   );

   modport slave (
      input i_Sample_Valid,
      input i_I_Data,
      input i_Q_Data
   );

endinterface

// File: rtl/edge_toggle_sync.sv
// Brings an asynchronous button into the clock domain, detects its rising
// edge and flips a toggle latch on every edge.
module edge_toggle_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic rise,
   output logic state
);

   logic meta;
   logic sync;
   logic sync_d;

   // NOTE: every register here uses non-blocking assignment so that all
   // stages sample their inputs from before the edge; blocking would
   // collapse the synchroniser chain into a single flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta   <= 1'b0;
         sync   <= 1'b0;
         sync_d <= 1'b0;
         state  <= 1'b0;
      end else begin
         meta   <= async_in;
         sync   <= meta;
         sync_d <= sync;
         state  <= state ^ rise;
      end
   end

   assign rise = sync & ~sync_d;

endmodule

// File: rtl/iq_uart_tx.sv
// I/Q UART transmitter: captures an I/Q pair into a one-deep holding buffer
// and sends it as two back-to-back 8N1 frames, I then Q, LSB first.
module iq_uart_tx
   import iq_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 10,
   parameter int GAP_CLKS     = 1
) (
   input  logic         i_Clock,
   input  logic         i_Rst_n,
   input  logic         i_Enable,
   iq_uart_tx_if.slave  smp,
   output logic         o_Tx_Serial,
   output logic         o_Busy,
   output logic         o_Overrun,
   output logic         o_Tx_Enable,
   output logic         o_I_LED,
   output logic         o_Q_LED
);

   localparam int CLK_W = cnt_width(CLKS_PER_BIT);
   localparam int GAP_W = cnt_width(GAP_CLKS);

   localparam logic [CLK_W-1:0]     BIT_LAST  = CLK_W'(CLKS_PER_BIT - 1);
   localparam logic [GAP_W-1:0]     GAP_LAST  = GAP_W'(GAP_CLKS - 1);
   localparam logic [BIT_IDX_W-1:0] DATA_LAST = BIT_IDX_W'(DATA_BITS - 1);
   localparam logic [BIT_IDX_W-1:0] STOP_LAST = BIT_IDX_W'(STOP_BITS - 1);

   // ---------------------------------------------------------------
   // Enable gating
   // ---------------------------------------------------------------
   logic en_rise;
   logic tx_enable;

   edge_toggle_sync u_enable (
      .clk      (i_Clock),
      .rst_n    (i_Rst_n),
      .async_in (i_Enable),
      .rise     (en_rise),
      .state    (tx_enable)
   );

   assign o_Tx_Enable = tx_enable;

   // ---------------------------------------------------------------
   // Holding buffer
   // ---------------------------------------------------------------
   uart_state_e state;
   iq_pair_t    hold;
   logic        pending;
   logic        take;
   logic        capture_req;

   assign take        = (state == ST_IDLE) && pending;
   assign capture_req = smp.i_Sample_Valid && tx_enable && !en_rise;

   // NOTE: the buffer is a plain register, not a memory, so it is reset
   // along with everything else; a dropped sample must never reappear.
   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         hold      <= '0;
         pending   <= 1'b0;
         o_Overrun <= 1'b0;
      end else if (en_rise) begin
         // Toggle cycles never capture; a toggle to 0 flushes the buffer.
         o_Overrun <= 1'b0;
         if (tx_enable || take)
            pending <= 1'b0;
      end else if (capture_req) begin
         if (!pending || take) begin
            hold    <= '{i: smp.i_I_Data, q: smp.i_Q_Data};
            pending <= 1'b1;
         end else begin
            o_Overrun <= 1'b1;
         end
      end else if (take) begin
         pending <= 1'b0;
      end
   end

   // ---------------------------------------------------------------
   // Frame sequencer
   // ---------------------------------------------------------------
   iq_pair_t             work;
   iq_phase_e            phase;
   logic [CLK_W-1:0]     clk_cnt;
   logic [GAP_W-1:0]     gap_cnt;
   logic [BIT_IDX_W-1:0] bit_idx;
   sample_t              cur_byte;
   logic                 line;
   logic                 bit_end;

   assign cur_byte = (phase == PH_Q) ? work.q : work.i;
   assign bit_end  = (clk_cnt == BIT_LAST);

   // NOTE: default assignment first so no path through the case leaves
   // line unassigned, which would otherwise infer a latch.
   always_comb begin
      line = 1'b1;
      case (state)
         ST_START: line = 1'b0;
         ST_DATA:  line = cur_byte[bit_idx];
         default:  line = 1'b1;
      endcase
   end

   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         state       <= ST_IDLE;
         work        <= '0;
         phase       <= PH_I;
         clk_cnt     <= '0;
         gap_cnt     <= '0;
         bit_idx     <= '0;
         o_Tx_Serial <= 1'b1;
         o_Busy      <= 1'b0;
         o_I_LED     <= 1'b0;
         o_Q_LED     <= 1'b0;
      end else begin
         // The line register follows the state one cycle later.
         o_Tx_Serial <= line;
         case (state)
            ST_IDLE: begin
               if (pending) begin
                  work    <= hold;
                  phase   <= PH_I;
                  clk_cnt <= '0;
                  state   <= ST_START;
                  o_Busy  <= 1'b1;
               end
            end
            ST_START: begin
               if (bit_end) begin
                  clk_cnt <= '0;
                  bit_idx <= '0;
                  state   <= ST_DATA;
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
            ST_DATA: begin
               if (bit_end) begin
                  clk_cnt <= '0;
                  if (bit_idx == DATA_LAST) begin
                     bit_idx <= '0;
                     state   <= ST_STOP;
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                  end
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
            ST_STOP: begin
               if (bit_end) begin
                  clk_cnt <= '0;
                  if (bit_idx == STOP_LAST) begin
                     bit_idx <= '0;
                     gap_cnt <= '0;
                     state   <= ST_GAP;
                     if (phase == PH_I)
                        o_I_LED <= ~o_I_LED;
                     else
                        o_Q_LED <= ~o_Q_LED;
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                  end
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
            ST_GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  gap_cnt <= '0;
                  if (phase == PH_I) begin
                     phase   <= PH_Q;
                     clk_cnt <= '0;
                     state   <= ST_START;
                  end else begin
                     state  <= ST_IDLE;
                     o_Busy <= 1'b0;
                  end
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end
            default: begin
               state  <= ST_IDLE;
               o_Busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_iq_uart_tx.sv
// Self-checking bench for iq_uart_tx: a waveform-level reference model is
// compared every cycle, plus directed scenarios with hand-computed values.
module tb_iq_uart_tx;

   localparam int C         = 10;
   localparam int G         = 1;
   localparam int FRAME_LEN = 10 * C;
   localparam int PAIR_LEN  = 2 * (FRAME_LEN + G);
   localparam int I_STOP_END = FRAME_LEN - 1;
   localparam int Q_STOP_END = FRAME_LEN + G + FRAME_LEN - 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic en_in = 1'b0;
   logic tx, busy, ovr, tx_en, led_i, led_q;

   iq_uart_tx_if smp ();

   iq_uart_tx #(.CLKS_PER_BIT(C), .GAP_CLKS(G)) dut (
      .i_Clock     (clk),
      .i_Rst_n     (rst_n),
      .i_Enable    (en_in),
      .smp         (smp),
      .o_Tx_Serial (tx),
      .o_Busy      (busy),
      .o_Overrun   (ovr),
      .o_Tx_Enable (tx_en),
      .o_I_LED     (led_i),
      .o_Q_LED     (led_q)
   );

   always #50 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // ---------------- reference model ----------------
   // The pair is a precomputed line waveform; the model just plays it out.
   function automatic logic [PAIR_LEN-1:0] make_pair(input logic [7:0] i, input logic [7:0] q);
      logic [PAIR_LEN-1:0] w;
      logic [7:0] b;
      w = '1;
      for (int f = 0; f < 2; f++) begin
         b = (f == 0) ? i : q;
         for (int t = 0; t < C; t++) w[f*(FRAME_LEN+G) + t] = 1'b0;
         for (int j = 0; j < 8; j++)
            for (int t = 0; t < C; t++) w[f*(FRAME_LEN+G) + C*(1+j) + t] = b[j];
      end
      return w;
   endfunction

   logic [2:0] m_hist;
   logic m_en, m_pending, m_overrun, m_active, m_tx, m_busy, m_led_i, m_led_q;
   logic [7:0] m_bi, m_bq;
   int m_pos;
   logic [PAIR_LEN-1:0] m_wave;

   always @(posedge clk or negedge rst_n) begin : model
      logic tog, took, pend, act, ov, en, tx_n, li, lq;
      int pos;
      if (!rst_n) begin
         m_hist <= '0; m_en <= 1'b0; m_pending <= 1'b0; m_overrun <= 1'b0;
         m_active <= 1'b0; m_tx <= 1'b1; m_busy <= 1'b0; m_led_i <= 1'b0;
         m_led_q <= 1'b0; m_bi <= '0; m_bq <= '0; m_pos <= 0; m_wave <= '1;
      end else begin
         // Enable input reaches the toggle three edges after it rises.
         tog  = m_hist[1] & ~m_hist[2];
         pend = m_pending; act = m_active; pos = m_pos; ov = m_overrun;
         en = m_en; took = 1'b0; tx_n = 1'b1; li = m_led_i; lq = m_led_q;
         if (act) begin
            tx_n = m_wave[pos];
            if (pos == I_STOP_END) li = ~li;
            if (pos == Q_STOP_END) lq = ~lq;
            pos++;
            if (pos == PAIR_LEN) act = 1'b0;
         end else if (pend) begin
            m_wave <= make_pair(m_bi, m_bq);
            act = 1'b1; pos = 0; pend = 1'b0; took = 1'b1;
         end
         if (tog) begin
            en = ~en; ov = 1'b0;
            if (!en) pend = 1'b0;
         end else if (en && smp.i_Sample_Valid) begin
            if (!m_pending || took) begin
               pend = 1'b1;
               m_bi <= smp.i_I_Data;
               m_bq <= smp.i_Q_Data;
            end else begin
               ov = 1'b1;
            end
         end
         m_hist <= {m_hist[1:0], en_in};
         m_en <= en; m_pending <= pend; m_overrun <= ov; m_active <= act;
         m_pos <= pos; m_tx <= tx_n; m_busy <= act; m_led_i <= li; m_led_q <= lq;
      end
   end

   // ---------------- compare + line monitor ----------------
   logic prev_tx, prev_busy, prev_li, prev_lq, dec_busy;
   int dec_t;
   logic [7:0] dec_byte;
   int li_cnt = 0;
   int lq_cnt = 0;
   logic [7:0] rx_q[$];
   int start_q[$];
   int rise_q[$];
   int fall_q[$];

   always @(negedge clk) begin : monitor
      int j;
      if (!rst_n) begin
         dec_busy <= 1'b0; dec_t <= 0; prev_tx <= 1'b1;
         prev_busy <= 1'b0; prev_li <= 1'b0; prev_lq <= 1'b0;
      end else begin
         check("tx_line", tx, m_tx);
         check("busy", busy, m_busy);
         check("overrun", ovr, m_overrun);
         check("tx_enable", tx_en, m_en);
         check("i_led", led_i, m_led_i);
         check("q_led", led_q, m_led_q);
         prev_tx <= tx; prev_busy <= busy; prev_li <= led_i; prev_lq <= led_q;
         if (!prev_busy && busy) rise_q.push_back(cyc);
         if (prev_busy && !busy) fall_q.push_back(cyc);
         if (led_i != prev_li) li_cnt <= li_cnt + 1;
         if (led_q != prev_lq) lq_cnt <= lq_cnt + 1;
         if (!dec_busy) begin
            if (!tx) begin
               dec_busy <= 1'b1; dec_t <= 1; start_q.push_back(cyc);
            end
         end else begin
            dec_t <= dec_t + 1;
            if (dec_t >= C + C/2 && (dec_t - C/2) % C == 0) begin
               j = (dec_t - C/2) / C - 1;
               if (j < 8) dec_byte[j] <= tx;
               else begin
                  rx_q.push_back(dec_byte);
                  dec_busy <= 1'b0;
               end
            end
         end
      end
   end

   function automatic logic [7:0] rx_at(input int k);
      if (k < rx_q.size()) return rx_q[k];
      return 8'hxx;
   endfunction
   function automatic int start_at(input int k);
      if (k < start_q.size()) return start_q[k];
      return -1;
   endfunction
   function automatic int rise_at(input int k);
      if (k < rise_q.size()) return rise_q[k];
      return -1;
   endfunction
   function automatic int fall_at(input int k);
      if (k < fall_q.size()) return fall_q[k];
      return -1;
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic send(input logic [7:0] i, input logic [7:0] q, output int n);
      @(posedge clk); #2;
      smp.i_Sample_Valid = 1'b1; smp.i_I_Data = i; smp.i_Q_Data = q;
      @(posedge clk); #2;
      smp.i_Sample_Valid = 1'b0;
      n = cyc;
   endtask

   task automatic press();
      @(posedge clk); #2 en_in = 1'b1;
      repeat (4) @(posedge clk);
      #2 en_in = 1'b0;
   endtask

   task automatic wait_en(input logic val);
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (tx_en === val) break;
      end
      check("enable_wait", tx_en, val);
   endtask

   task automatic wait_idle(input int max);
      for (int k = 0; k < max; k++) begin
         @(negedge clk);
         if (busy === 1'b0) break;
      end
      check("idle_wait", busy, 1'b0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int n, m, x0, s0, r0, f0, li0, lq0, en_cnt;
      logic found;
      smp.i_Sample_Valid = 1'b0; smp.i_I_Data = '0; smp.i_Q_Data = '0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;

      // Reset then idle; a valid while disabled is ignored.
      repeat (100) @(negedge clk);
      check("idle_tx", tx, 1'b1);
      check("idle_busy", busy, 1'b0);
      check("idle_ovr", ovr, 1'b0);
      check("idle_en", tx_en, 1'b0);
      check("idle_leds", {led_i, led_q}, 2'b00);
      x0 = rx_q.size();
      send(8'hA5, 8'h3C, n);
      repeat (20) @(negedge clk);
      check("disabled_ovr", ovr, 1'b0);
      check("disabled_busy", busy, 1'b0);
      check("disabled_rx", rx_q.size() - x0, 0);

      // Single pair.
      press(); wait_en(1'b1);
      x0 = rx_q.size(); s0 = start_q.size(); r0 = rise_q.size(); f0 = fall_q.size();
      li0 = li_cnt; lq0 = lq_cnt;
      send(8'hA5, 8'h3C, n);
      repeat (5) @(negedge clk);
      check("pair_busy", busy, 1'b1);
      wait_idle(400);
      repeat (10) @(negedge clk);
      check("pair_rx_count", rx_q.size() - x0, 2);
      check("pair_i_byte", rx_at(x0), 8'hA5);
      check("pair_q_byte", rx_at(x0 + 1), 8'h3C);
      check("start_latency", start_at(s0) - n, 2);
      check("q_start_offset", start_at(s0 + 1) - n, 103);
      check("busy_latency", rise_at(r0) - n, 1);
      check("pair_length", fall_at(f0) - rise_at(r0), 202);
      check("i_led_toggles", li_cnt - li0, 1);
      check("q_led_toggles", lq_cnt - lq0, 1);

      // Buffered pair plus an overrun.
      x0 = rx_q.size(); r0 = rise_q.size(); f0 = fall_q.size();
      send(8'h01, 8'h02, n);
      repeat (3) @(posedge clk);
      send(8'h03, 8'h04, n);
      repeat (3) @(posedge clk);
      send(8'h05, 8'h06, n);
      @(negedge clk);
      check("overrun_set", ovr, 1'b1);
      repeat (210) @(negedge clk);
      wait_idle(400);
      repeat (10) @(negedge clk);
      check("buf_rx_count", rx_q.size() - x0, 4);
      check("buf_b0", rx_at(x0), 8'h01);
      check("buf_b1", rx_at(x0 + 1), 8'h02);
      check("buf_b2", rx_at(x0 + 2), 8'h03);
      check("buf_b3", rx_at(x0 + 3), 8'h04);
      check("pair_gap", rise_at(r0 + 1) - fall_at(f0), 1);
      check("overrun_sticky", ovr, 1'b1);

      // Disable mid-pair with a sample pending.
      x0 = rx_q.size();
      send(8'h5A, 8'hC3, n);
      send(8'h11, 8'h22, m);
      repeat (30) @(posedge clk);
      press(); wait_en(1'b0);
      @(negedge clk);
      check("disable_clears_ovr", ovr, 1'b0);
      check("disable_in_flight", busy, 1'b1);
      repeat (600) @(negedge clk);
      check("disable_rx_count", rx_q.size() - x0, 2);
      check("disable_i_byte", rx_at(x0), 8'h5A);
      check("disable_q_byte", rx_at(x0 + 1), 8'hC3);
      check("disable_idle", busy, 1'b0);

      // Capture in the same cycle the buffer is taken.
      press(); wait_en(1'b1);
      x0 = rx_q.size();
      send(8'hA1, 8'hA2, n);
      send(8'hB1, 8'hB2, m);
      found = 1'b0;
      for (int k = 0; k < 400; k++) begin
         @(posedge clk); #2;
         if (busy === 1'b0) begin found = 1'b1; break; end
      end
      check("take_window", found, 1'b1);
      smp.i_Sample_Valid = 1'b1; smp.i_I_Data = 8'hC1; smp.i_Q_Data = 8'hC2;
      @(posedge clk); #2 smp.i_Sample_Valid = 1'b0;
      @(negedge clk);
      check("take_capture_ovr", ovr, 1'b0);
      repeat (450) @(negedge clk);
      wait_idle(400);
      repeat (10) @(negedge clk);
      check("take_rx_count", rx_q.size() - x0, 6);
      check("take_b2", rx_at(x0 + 2), 8'hB1);
      check("take_b4", rx_at(x0 + 4), 8'hC1);
      check("take_b5", rx_at(x0 + 5), 8'hC2);
      check("take_ovr_final", ovr, 1'b0);

      // Asynchronous reset during data bit 4 of I.
      send(8'h86, 8'h69, n);
      repeat (54) @(posedge clk);
      #2;
      check("pre_reset_bit4", tx, 1'b0);
      rst_n = 1'b0;
      #1;
      check("reset_tx", tx, 1'b1);
      check("reset_busy", busy, 1'b0);
      check("reset_leds", {led_i, led_q}, 2'b00);
      check("reset_en", tx_en, 1'b0);
      @(posedge clk); #2 rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check("post_reset_tx", tx, 1'b1);

      // Randomised traffic with occasional enable toggles.
      press(); wait_en(1'b1);
      en_cnt = 0;
      for (int k = 0; k < 8000; k++) begin
         @(posedge clk); #2;
         smp.i_Sample_Valid = ($urandom_range(0, 29) == 0);
         smp.i_I_Data = 8'($urandom);
         smp.i_Q_Data = 8'($urandom);
         if (en_cnt > 0) begin
            en_cnt--;
            if (en_cnt == 0) en_in = 1'b0;
         end else if ($urandom_range(0, 1999) == 0) begin
            en_in = 1'b1; en_cnt = 4;
         end
      end
      smp.i_Sample_Valid = 1'b0; en_in = 1'b0;
      repeat (500) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
